// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 19-bit data / 15-bit PC five-stage pipeline.
// Operand forwarding, ALU, branch/jump resolution, and the EX/MEM register.
// Build option: define EXECUTE_FORWARD_EN to include the forwarding muxes;
// without it, SrcA = RD1E and store data = RD2E, and the hazard unit stalls.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        ALUSrcE,
    input  logic        ResultSrcE,
    input  logic        Cant_ByteE,
    input  logic [1:0]  BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [18:0] RD1E,
    input  logic [18:0] RD2E,
    input  logic [18:0] ImmExtE,
    input  logic [14:0] PCE,
    input  logic [4:0]  RDE,
    input  logic [4:0]  RS1E,
    input  logic [4:0]  RS2E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [18:0] ResultW,
    output logic        PCSrcE,
    output logic [14:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic        Cant_ByteM,
    output logic [18:0] ALUResultM,
    output logic [18:0] WriteDataM,
    output logic [4:0]  RdM
);

    localparam int unsigned DW = 19;
    localparam int unsigned PW = 15;
    localparam int unsigned RW = 5;

    logic [DW-1:0] r_alu_result;
    logic [DW-1:0] r_write_data;
    logic [RW-1:0] r_rd;
    logic          r_reg_write;
    logic          r_mem_write;
    logic          r_result_src;
    logic          r_cant_byte;

    logic [DW-1:0] w_src_a;
    logic [DW-1:0] w_fwd_b;
    logic [DW-1:0] w_src_b;
    logic [DW-1:0] w_diff;
    logic [DW-1:0] w_alu;
    logic [RW-1:0] w_shamt;
    logic          w_zero;
    logic          w_less;
    logic          w_ovf;
    logic          w_unused;

`ifdef EXECUTE_FORWARD_EN
    // Operand forwarding: 01 takes writeback, 10 takes our own EX/MEM result.
    always_comb begin
        w_src_a = RD1E;
        w_fwd_b = RD2E;
        case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = r_alu_result;
            default: w_fwd_b = RD2E;
        endcase
    end
    assign w_unused = ^{RS1E, RS2E};
`else
    // No forwarding: register-file operands are used as-is.
    always_comb begin
        w_src_a = RD1E;
        w_fwd_b = RD2E;
    end
    assign w_unused = ^{RS1E, RS2E, ForwardAE, ForwardBE, ResultW};
`endif

    assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;
    assign w_shamt = w_src_b[RW-1:0];

    // Dedicated compare subtractor: Zero and signed Less independent of the ALU op.
    always_comb begin
        w_diff = w_src_a - w_src_b;
        w_zero = (w_diff == '0);
        w_ovf  = (w_src_a[DW-1] ^ w_src_b[DW-1]) & (w_diff[DW-1] ^ w_src_a[DW-1]);
        w_less = w_diff[DW-1] ^ w_ovf;
    end

    // ALU; shifts by 19..31 produce zero.
    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            3'b000: w_alu = w_src_a + w_src_b;
            3'b001: w_alu = w_diff;
            3'b010: w_alu = w_src_a & w_src_b;
            3'b011: w_alu = w_src_a | w_src_b;
            3'b100: w_alu = w_src_a ^ w_src_b;
            3'b101: w_alu = (w_shamt < RW'(DW)) ? (w_src_a << w_shamt) : '0;
            3'b110: w_alu = (w_shamt < RW'(DW)) ? (w_src_a >> w_shamt) : '0;
            3'b111: w_alu = DW'(w_less);
            default: w_alu = '0;
        endcase
    end

    // Redirect decision and target back to fetch, zero-cycle.
    always_comb begin
        PCSrcE = JumpE
               | ((BranchE == 2'b01) &  w_zero)
               | ((BranchE == 2'b10) & ~w_zero)
               | ((BranchE == 2'b11) &  w_less);
        PCTargetE = PCE + ImmExtE[PW-1:0];
    end

    // EX/MEM pipeline register, loads every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_cant_byte  <= 1'b0;
        end else begin
            r_alu_result <= w_alu;
            r_write_data <= w_fwd_b;
            r_rd         <= RDE;
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_cant_byte  <= Cant_ByteE;
        end
    end

    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign RdM        = r_rd;
    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign Cant_ByteM = r_cant_byte;

endmodule
